cu_seq: RTL and testbench

Parametrised multi-cycle control unit for the mycpu datapath, and the successor to the fixed 16-bit decoder. Register-address width and loop depth are generic, and memory fetch/load/store stall on a ready handshake. Multiply waits for an ALU-done handshake, illegal opcodes are trapped, and HALT resumes on a run strobe. It sits between the instruction register and the datapath and drives all datapath control outputs as Mealy functions of state, instruction and flags.

---
 rtl/cu_seq_if.sv | 38 +++
 rtl/cu_seq.sv | 179 +++++++++++++++++
 tb/tb_cu_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_seq_if.sv
// Control-unit bus: instruction/flag/handshake inputs and the datapath control outputs.
// master is the control unit's view; slave is the view of whatever surrounds it.
interface cu_seq_if #(
    parameter int IW  = 16,
    parameter int RAW = 3
);
    logic [IW-1:0]      ins_in;
    logic               z_in;
    logic               n_in;
    logic               mem_rdy_in;
    logic               alu_done_in;
    logic               run_in;
    logic               il_out;
    logic               rw_out;
    logic               mm_out;
    logic               mb_out;
    logic               iom_out;
    logic               wen_out;
    logic [1:0]         ps_out;
    logic [3*RAW-1:0]   rs_out;
    logic [1:0]         md_out;
    logic [3:0]         fs_out;
    logic               halted_out;
    logic               illegal_out;
    logic [2:0]         state_out;

    modport master (
        input  ins_in, z_in, n_in, mem_rdy_in, alu_done_in, run_in,
        output il_out, rw_out, mm_out, mb_out, iom_out, wen_out, ps_out,
               rs_out, md_out, fs_out, halted_out, illegal_out, state_out
    );

    modport slave (
        output ins_in, z_in, n_in, mem_rdy_in, alu_done_in, run_in,
        input  il_out, rw_out, mm_out, mb_out, iom_out, wen_out, ps_out,
               rs_out, md_out, fs_out, halted_out, illegal_out, state_out
    );
endinterface

// File: rtl/cu_seq.sv
// Multi-cycle control unit: fetch/execute sequencer with memory and ALU stalls,
// an XXL shift loop, illegal-opcode trap and halt/resume. Outputs are Mealy.
module cu_seq #(
    parameter int IW       = 16,
    parameter int RAW      = 3,
    parameter int LOOP_MAX = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    cu_seq_if.master  bus
);
    localparam int OPW = IW - 3 * RAW;
    localparam int CW  = (LOOP_MAX > 1) ? $clog2(LOOP_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOOP_MAX - 1);

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_INF = 3'd1,
        S_EX0 = 3'd2,
        S_XL  = 3'd3,
        S_HLT = 3'd4
    } state_t;

    state_t          state, state_n;
    logic            illegal_q;
    logic [CW-1:0]   cnt;
    logic            illegal_set, illegal_clr, cnt_clr, cnt_inc;

    logic [OPW-1:0]  op;
    logic [6:0]      low7;
    logic [3:0]      f;
    logic            hi_zero;

    logic            il, rw, mm, mb, iom, wen, halted;
    logic [1:0]      ps, md;
    logic [3*RAW-1:0] rs;
    logic [3:0]      fs;

    assign op      = bus.ins_in[IW-1:3*RAW];
    assign low7    = op[6:0];
    assign f       = op[3:0];
    // Opcode bits above the 7-bit map must be zero for a legal instruction.
    assign hi_zero = (op >> 7) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            if (illegal_set)      illegal_q <= 1'b1;
            else if (illegal_clr) illegal_q <= 1'b0;
            if (cnt_clr)          cnt <= '0;
            else if (cnt_inc)     cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        illegal_set = 1'b0;
        illegal_clr = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        il = 1'b0; rw = 1'b0; mm = 1'b0; mb = 1'b0; iom = 1'b0; wen = 1'b1;
        halted = 1'b0;
        ps = 2'b00; md = 2'b00; rs = '0; fs = 4'b0000;
        case (state)
            S_RST: state_n = S_INF;
            S_INF: begin
                mm = 1'b1;
                il = bus.mem_rdy_in;
                if (bus.mem_rdy_in) state_n = S_EX0;
            end
            S_EX0: begin
                rs = bus.ins_in[3*RAW-1:0];
                if (!hi_zero) begin
                    illegal_set = 1'b1;
                    state_n     = S_HLT;
                end else begin
                    casez (low7)
                        7'b00?????: begin
                            fs = f;
                            mb = low7[4];
                            // fs 0011 is the multi-cycle multiply: wait for the ALU.
                            if (f == 4'b0011) begin
                                rw = bus.alu_done_in;
                                if (bus.alu_done_in) begin
                                    ps      = 2'b01;
                                    state_n = S_INF;
                                end
                            end else begin
                                rw      = 1'b1;
                                ps      = 2'b01;
                                state_n = S_INF;
                            end
                        end
                        7'b0100000: begin
                            md = 2'b01;
                            rw = bus.mem_rdy_in;
                            if (bus.mem_rdy_in) begin
                                ps      = 2'b01;
                                state_n = S_INF;
                            end
                        end
                        7'b0100001: begin
                            wen = 1'b0;
                            if (bus.mem_rdy_in) begin
                                ps      = 2'b01;
                                state_n = S_INF;
                            end
                        end
                        7'b0110000: begin
                            iom = 1'b1; md = 2'b10; rw = 1'b1; ps = 2'b01;
                            state_n = S_INF;
                        end
                        7'b0110001: begin
                            iom = 1'b1; wen = 1'b0; ps = 2'b01;
                            state_n = S_INF;
                        end
                        7'b1000000: begin
                            ps      = bus.z_in ? 2'b10 : 2'b01;
                            state_n = S_INF;
                        end
                        7'b1000001: begin
                            ps      = bus.n_in ? 2'b10 : 2'b01;
                            state_n = S_INF;
                        end
                        7'b1000010: begin
                            ps      = 2'b11;
                            state_n = S_INF;
                        end
                        7'b1010000: begin
                            cnt_clr = 1'b1;
                            state_n = S_XL;
                        end
                        7'b1111111: state_n = S_HLT;
                        default: begin
                            illegal_set = 1'b1;
                            state_n     = S_HLT;
                        end
                    endcase
                end
            end
            S_XL: begin
                fs = 4'b1110;
                rw = 1'b1;
                if (bus.z_in || cnt == CNT_LAST) begin
                    ps      = 2'b01;
                    state_n = S_INF;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HLT: begin
                halted = 1'b1;
                if (bus.run_in) begin
                    illegal_clr = 1'b1;
                    state_n     = S_INF;
                end
            end
            default: state_n = S_RST;
        endcase
    end

    assign bus.il_out      = il;
    assign bus.rw_out      = rw;
    assign bus.mm_out      = mm;
    assign bus.mb_out      = mb;
    assign bus.iom_out     = iom;
    assign bus.wen_out     = wen;
    assign bus.ps_out      = ps;
    assign bus.rs_out      = rs;
    assign bus.md_out      = md;
    assign bus.fs_out      = fs;
    assign bus.halted_out  = halted;
    assign bus.illegal_out = illegal_q;
    assign bus.state_out   = state;
endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: per-instruction cycle traces are built from the opcode rules
// and queued; a negedge monitor compares every DUT cycle against the queue.
module tb_cu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cu_seq_if #(.IW(16), .RAW(3)) bus ();
  cu_seq #(.IW(16), .RAW(3), .LOOP_MAX(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [24:0] exp_q[$];
  logic [24:0] act, mon_e;
  int  checks = 0;
  int  passed = 0;
  logic flag = 1'b0;
  logic done = 1'b0;

  assign act = {bus.il_out, bus.rw_out, bus.mm_out, bus.mb_out, bus.iom_out, bus.wen_out,
                bus.ps_out, bus.rs_out, bus.md_out, bus.fs_out, bus.halted_out, bus.illegal_out};

  function automatic logic [24:0] mk(input logic il, rw, mm, mb, iom, wen,
                                     input logic [1:0] ps, input logic [8:0] rs,
                                     input logic [1:0] md, input logic [3:0] fs,
                                     input logic halted, illegal);
    return {il, rw, mm, mb, iom, wen, ps, rs, md, fs, halted, illegal};
  endfunction

  function automatic logic [24:0] dflt();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, flag);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op < 7'h20) || (op inside {7'h20, 7'h21, 7'h30, 7'h31, 7'h40, 7'h41, 7'h42, 7'h50, 7'h7F});
  endfunction

  // Watchdog: the whole run must finish within a bounded time.
  initial begin
    #2000000;
    if (!done) begin
      checks++;
      $display("FAIL timeout t=%0t: sequence did not complete, %0d expectations pending",
               $time, exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  // Immediate comparison of the live outputs (used right after asynchronous reset).
  task automatic check_now(input string name, input logic [24:0] e);
    checks++;
    if (act === e) passed++;
    else $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, e);
  endtask

  // Monitor: one queued expectation per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (act === mon_e) passed++;
      else $display("FAIL cycle_outputs t=%0t actual={il,rw,mm,mb,iom,wen,ps,rs,md,fs,halt,ill}=%b expected=%b",
                    $time, act, mon_e);
    end else if (done) begin
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  task automatic cyc(input logic rdy, adone, z, n, run, input logic [24:0] e);
    bus.mem_rdy_in  = rdy;
    bus.alu_done_in = adone;
    bus.z_in        = z;
    bus.n_in        = n;
    bus.run_in      = run;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++)
      cyc(0, rb(), rb(), rb(), rb(), mk(0, 0, 1, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, flag));
    cyc(1, rb(), rb(), rb(), rb(), mk(1, 0, 1, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, flag));
  endtask

  task automatic halt(input int hw);
    for (int i = 0; i < hw; i++)
      cyc(rb(), rb(), rb(), rb(), 0, mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 1, flag));
    cyc(rb(), rb(), rb(), rb(), 1, mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 1, flag));
    flag = 1'b0;
  endtask

  // fw: fetch wait cycles, ew: execute stall cycles, zx: XL cycle on which z rises (0 = never),
  // hw: HLT cycles before the run strobe.
  task automatic run_instr(input logic [15:0] ins, input int fw, ew, zx, hw);
    logic [6:0] op;
    logic [8:0] r;
    logic [3:0] f;
    logic       zz, imm;
    int         nxl;
    op = ins[15:9];
    r  = ins[8:0];
    f  = ins[12:9];
    imm = op[4];
    bus.ins_in = ins;
    fetch(fw);
    if (op < 7'h20) begin
      if (f == 4'b0011) begin
        for (int i = 0; i < ew; i++)
          cyc(rb(), 0, rb(), rb(), rb(), mk(0, 0, 0, imm, 0, 1, 2'b00, r, 2'b00, f, 0, flag));
        cyc(rb(), 1, rb(), rb(), rb(), mk(0, 1, 0, imm, 0, 1, 2'b01, r, 2'b00, f, 0, flag));
      end else begin
        cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 1, 0, imm, 0, 1, 2'b01, r, 2'b00, f, 0, flag));
      end
    end else begin
      case (op)
        7'h20: begin
          for (int i = 0; i < ew; i++)
            cyc(0, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, r, 2'b01, 4'd0, 0, flag));
          cyc(1, rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0, 1, 2'b01, r, 2'b01, 4'd0, 0, flag));
        end
        7'h21: begin
          for (int i = 0; i < ew; i++)
            cyc(0, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b00, r, 2'b00, 4'd0, 0, flag));
          cyc(1, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b01, r, 2'b00, 4'd0, 0, flag));
        end
        7'h30: cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 1, 1, 2'b01, r, 2'b10, 4'd0, 0, flag));
        7'h31: cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 1, 0, 2'b01, r, 2'b00, 4'd0, 0, flag));
        7'h40: begin
          zz = rb();
          cyc(rb(), rb(), zz, rb(), rb(), mk(0, 0, 0, 0, 0, 1, zz ? 2'b10 : 2'b01, r, 2'b00, 4'd0, 0, flag));
        end
        7'h41: begin
          zz = rb();
          cyc(rb(), rb(), rb(), zz, rb(), mk(0, 0, 0, 0, 0, 1, zz ? 2'b10 : 2'b01, r, 2'b00, 4'd0, 0, flag));
        end
        7'h42: cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b11, r, 2'b00, 4'd0, 0, flag));
        7'h50: begin
          cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, r, 2'b00, 4'd0, 0, flag));
          nxl = (zx > 0) ? zx : 16;
          for (int i = 1; i <= nxl; i++) begin
            zz = (zx > 0) && (i == nxl);
            cyc(rb(), rb(), zz, rb(), rb(),
                mk(0, 1, 0, 0, 0, 1, (i == nxl) ? 2'b01 : 2'b00, 9'd0, 2'b00, 4'b1110, 0, flag));
          end
        end
        7'h7F: begin
          cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, r, 2'b00, 4'd0, 0, flag));
          halt(hw);
        end
        default: begin
          cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, r, 2'b00, 4'd0, 0, flag));
          flag = 1'b1;
          halt(hw);
        end
      endcase
    end
  endtask

  function automatic logic [6:0] rand_op();
    int k;
    logic [6:0] op;
    k = $urandom_range(0, 99);
    if (k < 30)      op = {2'b00, 5'($urandom_range(0, 31))};
    else if (k < 40) op = 7'h20;
    else if (k < 48) op = 7'h21;
    else if (k < 53) op = 7'h30;
    else if (k < 58) op = 7'h31;
    else if (k < 65) op = 7'h40;
    else if (k < 72) op = 7'h41;
    else if (k < 77) op = 7'h42;
    else if (k < 85) op = 7'h50;
    else if (k < 89) op = 7'h7F;
    else begin
      op = 7'($urandom_range(0, 127));
      while (is_legal(op)) op = 7'($urandom_range(0, 127));
    end
    return op;
  endfunction

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0;
    bus.ins_in = '0; bus.z_in = 0; bus.n_in = 0;
    bus.mem_rdy_in = 0; bus.alu_done_in = 0; bus.run_in = 0;
    @(posedge clk);
    #1;
    check_now("reset_state", mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, 0));
    cyc(1, 1, 0, 0, 1, dflt());
    cyc(1, 1, 0, 0, 1, dflt());
    rst_n = 1'b1;
    cyc(rb(), rb(), rb(), rb(), rb(), dflt());

    run_instr(16'h0453, 0, 0, 0, 0);
    run_instr(16'h40D1, 0, 3, 0, 0);
    run_instr(16'h0653, 0, 2, 0, 0);
    run_instr(16'hA000, 0, 0, 0, 0);
    run_instr(16'hA000, 1, 0, 3, 0);
    run_instr({7'h55, 9'h000}, 0, 0, 0, 1);

    for (int i = 0; i < 150; i++) begin
      ins = {rand_op(), 9'($urandom_range(0, 511))};
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
                rb() ? $urandom_range(1, 16) : 0, $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a stalled store.
    bus.ins_in = {7'h21, 9'h1AB};
    fetch(0);
    cyc(0, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b00, 9'h1AB, 2'b00, 4'd0, 0, flag));
    cyc(0, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b00, 9'h1AB, 2'b00, 4'd0, 0, flag));
    rst_n = 1'b0;
    flag  = 1'b0;
    #1;
    check_now("reset_state_mid_st", mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, 0));
    cyc(0, rb(), rb(), rb(), rb(), dflt());
    cyc(rb(), rb(), rb(), rb(), rb(), dflt());
    rst_n = 1'b1;
    cyc(rb(), rb(), rb(), rb(), rb(), dflt());
    run_instr(16'h0453, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an XXL loop.
    bus.ins_in = 16'hA000;
    fetch(0);
    cyc(rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, flag));
    cyc(rb(), rb(), 0, rb(), rb(), mk(0, 1, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'b1110, 0, flag));
    rst_n = 1'b0;
    #1;
    check_now("reset_state_mid_xl", mk(0, 0, 0, 0, 0, 1, 2'b00, 9'd0, 2'b00, 4'd0, 0, 0));
    cyc(rb(), rb(), 0, rb(), rb(), dflt());
    rst_n = 1'b1;
    cyc(rb(), rb(), rb(), rb(), rb(), dflt());
    run_instr(16'h40D1, 1, 1, 0, 0);

    done = 1'b1;
  end
endmodule
